gf180mcu_osu_sc_gp12t3v3__subf_ser: RTL and testbench
=====================================================

# gf180mcu_osu_sc_gp12t3v3__subf_ser

Bit-serial W-bit subtractor that computes D = A − B − BI, one bit per clock, LSB first. It uses a single full-subtractor slice with a registered borrow. It is the subtract-direction companion to the library's full-adder cell, intended for area-minimal datapaths built from this 12-track 3.3 V cell set. Operands and results use parallel valid/ready handshakes on both sides; one operation is in flight at a time.

## Interface
- W, 8: operand/result width in bits; legal range W ≥ 2.
- CLK  input  1  clock; all state updates on the rising edge.
- R  input  1  reset; asynchronous, active-high.
- A  input  W  minuend; sampled only at the accept edge.
- B  input  W  subtrahend; sampled only at the accept edge.
- BI  input  1  borrow-in; sampled only at the accept edge.
- IN_VALID  input  1  operands valid.
- IN_READY  output  1  block can accept operands; equals (state==IDLE) & ~R.
- D  output  W  difference, (A − B − BI) mod 2^W.
- BO  output  1  borrow-out; 1 iff A < B + BI, treating all values as unsigned.
- OUT_VALID  output  1  D/BO hold a new result.
- OUT_READY  input  1  consumer accepts the result.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - On an edge with IN_VALID & IN_READY (the accept edge), capture A→opa and B→opb.
  - Load the borrow register with BI and set bit counter = 0.
  - Go to SHIFT.
- SHIFT, each edge:
  - a = opa[0], b = opb[0], bin = borrow register.
  - d = a ^ b ^ bin; bout = (~a & b) | (~a & bin) | (b & bin).
  - Shift opa and opb right by 1, shift d into the MSB of the partial-result register, set borrow register = bout, increment the counter.
- End of SHIFT: on the edge where the counter reaches W−1 (bit W−1 processed), go to DONE. On that same edge:
  - D ← completed partial-result register, including bit W−1.
  - BO ← bout of bit W−1.
  - OUT_VALID ← 1.
- DONE:
  - Hold D, BO and OUT_VALID stable.
  - On an edge with OUT_VALID & OUT_READY: OUT_VALID ← 0, go to IDLE.
  - D and BO keep the last result until the next completion.
- IN_READY is 0 in SHIFT and DONE. IN_VALID in those states is ignored, and no operand capture occurs.
- Operand changes after the accept edge have no effect on the in-flight operation.
- Counter width is clog2(W). The counter never wraps within an operation; it is re-zeroed at each accept.

## Timing
- Reset values, applied immediately while R=1 (asynchronous): D=0, BO=0, OUT_VALID=0, IN_READY=0, state=IDLE, borrow register=0, counter=0.
- IN_READY rises combinationally when R falls.
- Latency: if accept is edge E0, OUT_VALID goes high after edge E0+W. It is first observable in the cycle following that edge.
- Result handshake completes at edge Ex, where OUT_VALID & OUT_READY. IN_READY=1 in the cycle after Ex.
- Minimum interval between accepts: W+2 cycles, with OUT_READY held at 1.
- OUT_READY=1 while not in DONE has no effect.
- Reset mid-operation (any state): the operation is abandoned, all registers return to reset values, and no result is produced. The first accept after R falls behaves as from power-up.
- No combinational path from any input to D, BO or OUT_VALID. IN_READY depends only on state and R.

## Test plan
- Reset:
  - Assert R for 3 cycles mid-idle → D=0, BO=0, OUT_VALID=0, IN_READY=0 during reset.
  - Release R → IN_READY=1 in the next cycle.
- Basic subtract, W=8:
  - A=0x5A, B=0x33, BI=0 → D=0x27, BO=0.
  - OUT_VALID is observed exactly 8 edges after the accept edge.
- Borrow/wrap cases:
  - A=0x00, B=0x01, BI=0 → D=0xFF, BO=1.
  - A=0x10, B=0x0F, BI=1 → D=0x00, BO=0.
  - A=0xFF, B=0xFF, BI=1 → D=0xFF, BO=1.
  - A=0x80, B=0x00, BI=1 → D=0x7F, BO=0.
- Backpressure:
  - Hold OUT_READY=0 for 5 cycles in DONE → D, BO and OUT_VALID stay stable, and IN_READY=0.
  - A new IN_VALID pulse with A=0x01 during DONE is ignored; the next result is unaffected.
- Operand isolation: change A and B every cycle during SHIFT → result equals the subtraction of the values captured at the accept edge.
- Reset mid-SHIFT:
  - Assert R after 3 bits of A=0x5A, B=0x33 → OUT_VALID never rises for that operation.
  - After release, A=0x05, B=0x07, BI=0 → D=0xFE, BO=1.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp12t3v3__subf_ser_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and OUT_READY; the slave (the subtractor) returns the result.
interface gf180mcu_osu_sc_gp12t3v3__subf_ser_if #(
  parameter int W = 8
);
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] D;
  logic         BO;
  logic         OUT_VALID;
  logic         OUT_READY;

  modport master (
    output A, B, BI, IN_VALID, OUT_READY,
    input  IN_READY, D, BO, OUT_VALID
  );

  modport slave (
    input  A, B, BI, IN_VALID, OUT_READY,
    output IN_READY, D, BO, OUT_VALID
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__subf_ser.sv
// Bit-serial W-bit subtractor: D = A - B - BI, one bit per clock, LSB first,
// through a single full-subtractor slice with a registered borrow.
module gf180mcu_osu_sc_gp12t3v3__subf_ser #(
  parameter int W = 8
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_gp12t3v3__subf_ser_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [W-1:0]   r_part;
  logic           r_brw;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_d;
  logic           r_bo;
  logic           r_ov;

  logic           w_in_rdy;
  logic           w_acc;
  logic           w_last;
  logic           w_hs;
  logic           w_a;
  logic           w_b;
  logic           w_d;
  logic           w_bout;

  // Full-subtractor slice on the current LSBs and the stored borrow.
  assign w_a    = r_opa[0];
  assign w_b    = r_opb[0];
  assign w_d    = w_a ^ w_b ^ r_brw;
  assign w_bout = (~w_a & w_b) | (~w_a & r_brw) | (w_b & r_brw);

  assign w_in_rdy      = (r_state == IDLE) & ~R;
  assign bus.IN_READY  = w_in_rdy;
  assign bus.D         = r_d;
  assign bus.BO        = r_bo;
  assign bus.OUT_VALID = r_ov;

  always_ff @(posedge CLK or posedge R) begin
    if (R) r_state <= IDLE;
    else   r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_acc  = 1'b0;
    w_last = 1'b0;
    w_hs   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.IN_VALID && w_in_rdy) begin
          w_acc = 1'b1;
          w_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_nxt  = DONE;
        end
      end
      DONE: begin
        if (r_ov && bus.OUT_READY) begin
          w_hs  = 1'b1;
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_part <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bo   <= 1'b0;
      r_ov   <= 1'b0;
    end else if (w_acc) begin
      r_opa <= bus.A;
      r_opb <= bus.B;
      r_brw <= bus.BI;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_opa  <= r_opa >> 1;
      r_opb  <= r_opb >> 1;
      r_part <= {w_d, r_part[W-1:1]};
      r_brw  <= w_bout;
      // Counter parks at W-1 on the last bit so it never wraps.
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_d  <= {w_d, r_part[W-1:1]};
        r_bo <= w_bout;
        r_ov <= 1'b1;
      end
    end else if (w_hs) begin
      r_ov <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__subf_ser.sv
// Randomized self-checking bench for the bit-serial subtractor against an
// arithmetic reference (A - B - BI with unsigned borrow-out).
module tb_gf180mcu_osu_sc_gp12t3v3__subf_ser;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic R   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  gf180mcu_osu_sc_gp12t3v3__subf_ser_if #(.W(W)) bus ();

  gf180mcu_osu_sc_gp12t3v3__subf_ser #(.W(W)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int unsigned av, sv;
    av = a;
    sv = b + bi;
    ref_sub[W-1:0] = W'((av - sv) & ((1 << W) - 1));
    ref_sub[W]     = (av < sv);
  endfunction

  // One full operation; hold = cycles of backpressure in DONE, scr = scramble
  // operands during SHIFT, inj = IN_VALID pulse during DONE.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input int hold, input bit scr, input bit inj);
    logic [W:0] e;
    int n, t;
    e = ref_sub(a, b, bi);
    @(negedge CLK);
    t = 0;
    while (bus.IN_READY !== 1'b1 && t < 30) begin @(negedge CLK); t++; end
    if (t >= 30) chk({nm, "_rdy_to"}, 0, 1);
    bus.A = a; bus.B = b; bus.BI = bi; bus.IN_VALID = 1'b1;
    bus.OUT_READY = (hold == 0);
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    n = 0;
    while (bus.OUT_VALID !== 1'b1 && n < 40) begin
      @(posedge CLK); #1; n++;
      if (scr) begin bus.A = W'($urandom); bus.B = W'($urandom); bus.BI = 1'($urandom); end
    end
    chk({nm, "_lat"}, n, W);
    chk({nm, "_d"}, bus.D, e[W-1:0]);
    chk({nm, "_bo"}, bus.BO, e[W]);
    for (int i = 0; i < hold; i++) begin
      if (inj && i == 0) begin bus.A = 8'h01; bus.B = 8'h00; bus.IN_VALID = 1'b1; end
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b0;
      chk({nm, "_hold_ov"}, bus.OUT_VALID, 1);
      chk({nm, "_hold_d"}, bus.D, e[W-1:0]);
      chk({nm, "_hold_bo"}, bus.BO, e[W]);
      chk({nm, "_hold_rdy"}, bus.IN_READY, 0);
    end
    bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    chk({nm, "_hs_ov"}, bus.OUT_VALID, 0);
    chk({nm, "_hs_rdy"}, bus.IN_READY, 1);
    chk({nm, "_keep_d"}, bus.D, e[W-1:0]);
    bus.OUT_READY = 1'b0;
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.BI = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_d", bus.D, 0);
      chk("rst_bo", bus.BO, 0);
      chk("rst_ov", bus.OUT_VALID, 0);
      chk("rst_rdy", bus.IN_READY, 0);
    end
    R = 1'b0;
    #1 chk("rel_rdy_comb", bus.IN_READY, 1);
    @(negedge CLK);
    chk("rel_rdy", bus.IN_READY, 1);

    do_op("basic", 8'h5A, 8'h33, 1'b0, 0, 1'b0, 1'b0);
    do_op("wrap0", 8'h00, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    do_op("bi10", 8'h10, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
    do_op("ffff", 8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
    do_op("x80", 8'h80, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    do_op("bp", 8'hC3, 8'h3C, 1'b0, 5, 1'b0, 1'b1);
    do_op("afterbp", 8'h22, 8'h11, 1'b0, 0, 1'b0, 1'b0);
    do_op("iso", 8'h9E, 8'hA7, 1'b1, 0, 1'b1, 1'b0);

    // Abandon an operation part-way through SHIFT.
    @(negedge CLK);
    bus.A = 8'h5A; bus.B = 8'h33; bus.BI = 1'b0; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
    @(posedge CLK); #1 bus.IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1 R = 1'b1;
    #1;
    chk("mid_rst_ov", bus.OUT_VALID, 0);
    chk("mid_rst_rdy", bus.IN_READY, 0);
    chk("mid_rst_d", bus.D, 0);
    repeat (2) @(negedge CLK);
    R = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (12) begin @(posedge CLK); #1; if (bus.OUT_VALID === 1'b1) seen++; end
      chk("mid_rst_noresult", seen, 0);
    end
    bus.OUT_READY = 1'b0;
    do_op("postrst", 8'h05, 8'h07, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++)
      do_op("rnd", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
